rsa_bus_master: RTL and testbench

Hardware initiator for the RSA peripheral's register bus. It replaces the processor-side write/poll/read sequence. On a start pulse it latches four 64-bit operands. It then writes them as 32-bit halves through the bit-switch register, writes the encrypt command, and waits for result_valid. Finally it reads back the 64-bit result and reports done or timeout. It sits between a local controller (for example a key-exchange FSM) and the rsa block's bus port.

---
 rtl/rsa_bus_master.sv | 220 ++++++++++++++++++++++
 tb/tb_rsa_bus_master.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_bus_master.sv
// Purpose : bus initiator that loads four 64-bit operands into the rsa peripheral
//           as 32-bit halves, issues encrypt, waits for result_valid, reads the result.
// Latency : first write one cycle after start; encrypt write at start+18; done 5 cycles
//           after result_valid is accepted, or TIMEOUT_CYCLES+1 cycles after encrypt.
// Backpressure: none on the bus (fixed one-cycle transfers); start is ignored while busy.
//
// Ports:
//   pclk, nreset                       clock, async active-low reset
//   start                              one-cycle request, sampled only in IDLE
//   message/exponent/modulus/residue   64-bit operands, latched on accepted start
//   bus_write_en/bus_read_en           registered strobes (never both high)
//   bus_addr/bus_write_data            registered address/data, zero when idle
//   bus_read_data                      read data, valid in the bus_read_en cycle
//   result_valid                       rsa completion flag
//   busy/done/timeout/result           status; timeout qualifies done
module rsa_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES   = 65535,
   parameter logic [7:0]  BIT_SWITCH_ADDR  = 8'h08,
   parameter logic [7:0]  MESSAGE_ADDR     = 8'h0C,
   parameter logic [7:0]  MODULUS_ADDR     = 8'h10,
   parameter logic [7:0]  EXPONENT_ADDR    = 8'h14,
   parameter logic [7:0]  RESIDUE_ADDR     = 8'h18,
   parameter logic [7:0]  RSA_ENCRYPT_ADDR = 8'h1C,
   parameter logic [7:0]  RESULT_ADDR      = 8'h20
) (
   input  logic        pclk,
   input  logic        nreset,
   input  logic        start,
   input  logic [63:0] message,
   input  logic [63:0] exponent,
   input  logic [63:0] modulus,
   input  logic [63:0] residue,
   output logic        bus_write_en,
   output logic        bus_read_en,
   output logic [7:0]  bus_addr,
   output logic [31:0] bus_write_data,
   input  logic [31:0] bus_read_data,
   input  logic        result_valid,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [63:0] result
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [4:0]  LAST_WRITE_STEP = 5'd17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WAIT,
      ST_READ,
      ST_DONE
   } state_t;

   state_t             state_q;
   logic [4:0]         step_q;
   logic [CNT_W-1:0]   tmo_cnt_q;
   logic [63:0]        msg_q, exp_q, mod_q, rsd_q;
   logic               bus_we_q, bus_re_q;
   logic [7:0]         bus_addr_q;
   logic [31:0]        bus_wdata_q;
   logic               busy_q, done_q, timeout_q;
   logic [63:0]        result_q;

   logic [4:0]         step_nxt_d;
   logic [CNT_W-1:0]   tmo_cnt_d;
   logic [7:0]         wr_addr_d;
   logic [31:0]        wr_data_d;
   logic [63:0]        wr_op;
   logic [7:0]         wr_op_addr;

   // Decode of the write word for the step that will be presented next cycle.
   // Steps 0..15 walk the operands in groups of four:
   // (BIT_SWITCH,0) (reg,lo) (BIT_SWITCH,1) (reg,hi).
   always_comb begin
      step_nxt_d = step_q + 5'd1;
      tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
      wr_op      = 64'h0;
      wr_op_addr = 8'h00;
      wr_addr_d  = 8'h00;
      wr_data_d  = 32'h0;
      case (step_nxt_d[4:2])
         3'd0: begin wr_op = msg_q; wr_op_addr = MESSAGE_ADDR;  end
         3'd1: begin wr_op = exp_q; wr_op_addr = EXPONENT_ADDR; end
         3'd2: begin wr_op = mod_q; wr_op_addr = MODULUS_ADDR;  end
         3'd3: begin wr_op = rsd_q; wr_op_addr = RESIDUE_ADDR;  end
         default: begin wr_op = 64'h0; wr_op_addr = 8'h00; end
      endcase
      if (step_nxt_d < 5'd16) begin
         case (step_nxt_d[1:0])
            2'd0: begin wr_addr_d = BIT_SWITCH_ADDR; wr_data_d = 32'h0;         end
            2'd1: begin wr_addr_d = wr_op_addr;      wr_data_d = wr_op[31:0];   end
            2'd2: begin wr_addr_d = BIT_SWITCH_ADDR; wr_data_d = 32'h1;         end
            default: begin wr_addr_d = wr_op_addr;   wr_data_d = wr_op[63:32];  end
         endcase
      end else if (step_nxt_d == 5'd16) begin
         wr_addr_d = BIT_SWITCH_ADDR;
         wr_data_d = 32'h0;
      end else if (step_nxt_d == LAST_WRITE_STEP) begin
         wr_addr_d = RSA_ENCRYPT_ADDR;
         wr_data_d = 32'h1;
      end
   end

   always_ff @(posedge pclk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= ST_IDLE;
         step_q      <= 5'd0;
         tmo_cnt_q   <= '0;
         msg_q       <= 64'h0;
         exp_q       <= 64'h0;
         mod_q       <= 64'h0;
         rsd_q       <= 64'h0;
         bus_we_q    <= 1'b0;
         bus_re_q    <= 1'b0;
         bus_addr_q  <= 8'h00;
         bus_wdata_q <= 32'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         result_q    <= 64'h0;
      end else begin
         // Bus is idle and zero unless a branch below issues a transfer.
         bus_we_q    <= 1'b0;
         bus_re_q    <= 1'b0;
         bus_addr_q  <= 8'h00;
         bus_wdata_q <= 32'h0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !busy_q) begin
                  msg_q       <= message;
                  exp_q       <= exponent;
                  mod_q       <= modulus;
                  rsd_q       <= residue;
                  timeout_q   <= 1'b0;
                  busy_q      <= 1'b1;
                  step_q      <= 5'd0;
                  state_q     <= ST_WRITE;
                  bus_we_q    <= 1'b1;
                  bus_addr_q  <= BIT_SWITCH_ADDR;
                  bus_wdata_q <= 32'h0;
               end
            end
            ST_WRITE: begin
               if (step_q == LAST_WRITE_STEP) begin
                  state_q   <= ST_WAIT;
                  tmo_cnt_q <= '0;
               end else begin
                  step_q      <= step_nxt_d;
                  bus_we_q    <= 1'b1;
                  bus_addr_q  <= wr_addr_d;
                  bus_wdata_q <= wr_data_d;
               end
            end
            ST_WAIT: begin
               tmo_cnt_q <= tmo_cnt_d;
               // A zero count marks the first WAIT cycle, where result_valid may
               // still be left over from the previous operation.
               if (result_valid && (tmo_cnt_q != '0)) begin
                  state_q     <= ST_READ;
                  step_q      <= 5'd0;
                  bus_we_q    <= 1'b1;
                  bus_addr_q  <= BIT_SWITCH_ADDR;
                  bus_wdata_q <= 32'h0;
               end else if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_q   <= ST_DONE;
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            ST_READ: begin
               case (step_q[1:0])
                  2'd0: begin
                     step_q     <= 5'd1;
                     bus_re_q   <= 1'b1;
                     bus_addr_q <= RESULT_ADDR;
                  end
                  2'd1: begin
                     result_q[31:0] <= bus_read_data;
                     step_q         <= 5'd2;
                     bus_we_q       <= 1'b1;
                     bus_addr_q     <= BIT_SWITCH_ADDR;
                     bus_wdata_q    <= 32'h1;
                  end
                  2'd2: begin
                     step_q     <= 5'd3;
                     bus_re_q   <= 1'b1;
                     bus_addr_q <= RESULT_ADDR;
                  end
                  default: begin
                     result_q[63:32] <= bus_read_data;
                     state_q         <= ST_DONE;
                     done_q          <= 1'b1;
                     busy_q          <= 1'b0;
                  end
               endcase
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus_write_en   = bus_we_q;
   assign bus_read_en    = bus_re_q;
   assign bus_addr       = bus_addr_q;
   assign bus_write_data = bus_wdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign timeout        = timeout_q;
   assign result         = result_q;

endmodule

// File: tb/tb_rsa_bus_master.sv
// Purpose : checks rsa_bus_master against a transaction-level model of the bus sequence.
// Latency : n/a (testbench).
// Backpressure: n/a; a responder models the rsa block's result_valid and read data.
module tb_rsa_bus_master;

   localparam int T_B = 20;
   localparam int T_A = 65535;

   logic        pclk;
   logic        nreset;
   logic        start_a, start_b;
   logic [63:0] message, exponent, modulus, residue;
   logic        rv_a, rv_b;
   logic [31:0] rd_a, rd_b;
   logic        we_a, re_a, busy_a, done_a, to_a;
   logic [7:0]  addr_a;
   logic [31:0] wd_a;
   logic [63:0] res_a;
   logic        we_b, re_b, busy_b, done_b, to_b;
   logic [7:0]  addr_b;
   logic [31:0] wd_b;
   logic [63:0] res_b;

   rsa_bus_master u_dut (
      .pclk(pclk), .nreset(nreset), .start(start_a),
      .message(message), .exponent(exponent), .modulus(modulus), .residue(residue),
      .bus_write_en(we_a), .bus_read_en(re_a), .bus_addr(addr_a), .bus_write_data(wd_a),
      .bus_read_data(rd_a), .result_valid(rv_a),
      .busy(busy_a), .done(done_a), .timeout(to_a), .result(res_a)
   );

   rsa_bus_master #(.TIMEOUT_CYCLES(T_B)) u_dut_to (
      .pclk(pclk), .nreset(nreset), .start(start_b),
      .message(message), .exponent(exponent), .modulus(modulus), .residue(residue),
      .bus_write_en(we_b), .bus_read_en(re_b), .bus_addr(addr_b), .bus_write_data(wd_b),
      .bus_read_data(rd_b), .result_valid(rv_b),
      .busy(busy_b), .done(done_b), .timeout(to_b), .result(res_b)
   );

   typedef struct packed {
      int          cyc;
      logic        rd;
      logic [7:0]  addr;
      logic [31:0] dat;
   } xfer_t;

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   xfer_t obs_q[$];
   xfer_t exp_q[$];
   int    done_q[$];
   logic  to_seen_q[$];
   int    bus_err = 0;
   bit    busy_at[int];
   int    b_wr, b_rd, b_done_n, b_done_cyc;
   logic  b_to;
   logic [63:0] resp_res;
   int    resp_delay, resp_cnt;
   bit    resp_stale;
   logic  bs;

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial forever begin
      @(posedge pclk);
      cyc++;
   end

   // Bus monitor: records every transfer and done pulse with its cycle number.
   initial forever begin
      @(negedge pclk);
      busy_at[cyc] = busy_a;
      if (we_a && re_a) bus_err++;
      if (!we_a && !re_a && (addr_a != 8'h00 || wd_a != 32'h0)) bus_err++;
      if (we_a || re_a) obs_q.push_back('{cyc, re_a, addr_a, re_a ? 32'h0 : wd_a});
      if (done_a) begin done_q.push_back(cyc); to_seen_q.push_back(to_a); end
      if (we_b) b_wr++;
      if (re_b) b_rd++;
      if (done_b) begin b_done_n++; b_done_cyc = cyc; b_to = to_b; end
   end

   // rsa responder: result_valid rises resp_delay cycles after the encrypt write
   // and stays up until the next encrypt; reads return the half picked by bit-switch.
   initial forever begin
      @(negedge pclk);
      if (!nreset) begin
         rv_a = 1'b0; resp_cnt = 0; bs = 1'b0;
      end else begin
         if (we_a && addr_a == 8'h08) bs = wd_a[0];
         if (resp_stale) rv_a = 1'b1;
         else if (we_a && addr_a == 8'h1C) begin rv_a = 1'b0; resp_cnt = resp_delay; end
         else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) rv_a = 1'b1;
         end
      end
      rd_a = re_a ? (bs ? resp_res[63:32] : resp_res[31:0]) : $urandom;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic step_cycles(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic clear_obs();
      obs_q.delete(); done_q.delete(); to_seen_q.delete();
   endtask

   // Expected transfers for one operation started in cycle s. k = WAIT cycle in
   // which result_valid is first high (values below 2 mean "already high").
   task automatic build_model(input logic [63:0] m, e, md, r, input int s, input int k,
                              input int tmo, output int dexp, output bit toexp);
      logic [63:0] v[4];
      logic [7:0]  a[4];
      int c, ee, kk;
      v = '{m, e, md, r};
      a = '{8'h0C, 8'h14, 8'h10, 8'h18};
      exp_q.delete();
      c = s + 1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{c,     1'b0, 8'h08, 32'h0});
         exp_q.push_back('{c + 1, 1'b0, a[i],  v[i][31:0]});
         exp_q.push_back('{c + 2, 1'b0, 8'h08, 32'h1});
         exp_q.push_back('{c + 3, 1'b0, a[i],  v[i][63:32]});
         c += 4;
      end
      exp_q.push_back('{c,     1'b0, 8'h08, 32'h0});
      exp_q.push_back('{c + 1, 1'b0, 8'h1C, 32'h1});
      ee = s + 18;
      kk = (k < 2) ? 2 : k;
      if (kk <= tmo) begin
         exp_q.push_back('{ee + kk + 1, 1'b0, 8'h08, 32'h0});
         exp_q.push_back('{ee + kk + 2, 1'b1, 8'h20, 32'h0});
         exp_q.push_back('{ee + kk + 3, 1'b0, 8'h08, 32'h1});
         exp_q.push_back('{ee + kk + 4, 1'b1, 8'h20, 32'h0});
         dexp = ee + kk + 5; toexp = 1'b0;
      end else begin
         dexp = ee + tmo + 1; toexp = 1'b1;
      end
   endtask

   task automatic start_op_a(input logic [63:0] m, e, md, r, output int s);
      message = m; exponent = e; modulus = md; residue = r;
      start_a = 1'b1;
      s = cyc;
      step_cycles(1);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int limit);
      int n;
      n = 0;
      while (done_q.size() == 0 && n < limit) begin step_cycles(1); n++; end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      step_cycles(3);
      checks++;
      if ({we_a, re_a, addr_a, wd_a, busy_a, done_a, to_a, res_a} !== '0) begin
         errors++;
         $display("FAIL reset_a got we=%b re=%b addr=%h wd=%h busy=%b done=%b to=%b res=%h want all 0",
                  we_a, re_a, addr_a, wd_a, busy_a, done_a, to_a, res_a);
      end
      checks++;
      if ({we_b, re_b, addr_b, wd_b, busy_b, done_b, to_b, res_b} !== '0) begin
         errors++;
         $display("FAIL reset_b got outputs %h want 0", {we_b, re_b, addr_b, wd_b, busy_b, done_b, to_b, res_b});
      end
      nreset = 1'b1;
      step_cycles(2);
   endtask

   task automatic test_basic();
      logic [63:0] m, e, md, r;
      int s, dexp;
      bit toexp, ok;
      m = 64'h19992ea93fb8845b; e = 64'h044de026cabdb311;
      md = 64'heda515ef24029417; r = 64'h859cfcfb5a1f75d5;
      resp_res = 64'h19992ea93fb8845b; resp_delay = 50; resp_stale = 1'b0;
      clear_obs();
      start_op_a(m, e, md, r, s);
      wait_done_a(200);
      step_cycles(3);
      build_model(m, e, md, r, s, 50, T_A, dexp, toexp);
      checks++;
      if (done_q.size() != 1 || done_q[0] != dexp || to_seen_q[0] !== toexp) begin
         errors++;
         $display("FAIL basic_done got n=%0d cyc=%0d want n=1 cyc=%0d timeout=0",
                  done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, dexp);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL basic_count got %0d transfers want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL basic_xfer%0d got cyc=%0d rd=%b addr=%h dat=%h want cyc=%0d rd=%b addr=%h dat=%h", i,
                     obs_q[i].cyc, obs_q[i].rd, obs_q[i].addr, obs_q[i].dat,
                     exp_q[i].cyc, exp_q[i].rd, exp_q[i].addr, exp_q[i].dat);
         end
      end
      checks++;
      if (res_a !== 64'h19992ea93fb8845b || to_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_result got %h to=%b want 19992ea93fb8845b to=0", res_a, to_a);
      end
      ok = 1'b1;
      for (int c = s + 1; c < dexp; c++) if (!busy_at.exists(c) || busy_at[c] !== 1'b1) ok = 1'b0;
      checks++;
      if (!ok || busy_at[dexp] !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy got gap=%b busy_at_done=%b want gap=0 busy_at_done=0", !ok, busy_at[dexp]);
      end
   endtask

   task automatic test_stale_valid();
      logic [63:0] m, e, md, r;
      int s, dexp;
      bit toexp;
      m = {$urandom, $urandom}; e = {$urandom, $urandom};
      md = {$urandom, $urandom}; r = {$urandom, $urandom};
      resp_res = {$urandom, $urandom}; resp_stale = 1'b1;
      clear_obs();
      step_cycles(1);
      start_op_a(m, e, md, r, s);
      wait_done_a(100);
      resp_stale = 1'b0;
      step_cycles(3);
      build_model(m, e, md, r, s, 0, T_A, dexp, toexp);
      checks++;
      if (obs_q.size() != 22 || (obs_q[18].cyc - obs_q[17].cyc) < 2) begin
         errors++;
         $display("FAIL stale_gap got n=%0d gap=%0d want n=22 gap>=2", obs_q.size(),
                  (obs_q.size() > 18) ? obs_q[18].cyc - obs_q[17].cyc : -1);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stale_xfer%0d got cyc=%0d addr=%h dat=%h want cyc=%0d addr=%h dat=%h", i,
                     obs_q[i].cyc, obs_q[i].addr, obs_q[i].dat, exp_q[i].cyc, exp_q[i].addr, exp_q[i].dat);
         end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != dexp || res_a !== resp_res) begin
         errors++;
         $display("FAIL stale_done got n=%0d res=%h want n=1 cyc=%0d res=%h", done_q.size(), res_a, dexp, resp_res);
      end
   endtask

   task automatic test_start_while_busy();
      logic [63:0] m, e, md, r;
      int s, dexp;
      bit toexp;
      m = {$urandom, $urandom}; e = {$urandom, $urandom};
      md = {$urandom, $urandom}; r = {$urandom, $urandom};
      resp_res = {$urandom, $urandom}; resp_delay = $urandom_range(2, 20);
      clear_obs();
      start_op_a(m, e, md, r, s);
      step_cycles(5);
      message = ~m; exponent = ~e; modulus = ~md; residue = ~r;
      start_a = 1'b1;
      step_cycles(1);
      start_a = 1'b0;
      wait_done_a(200);
      step_cycles(4);
      build_model(m, e, md, r, s, resp_delay, T_A, dexp, toexp);
      checks++;
      if (done_q.size() != 1 || obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL busy_start got done=%0d xfers=%0d want done=1 xfers=%0d", done_q.size(), obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL busy_xfer%0d got cyc=%0d addr=%h dat=%h want cyc=%0d addr=%h dat=%h", i,
                     obs_q[i].cyc, obs_q[i].addr, obs_q[i].dat, exp_q[i].cyc, exp_q[i].addr, exp_q[i].dat);
         end
      end
   endtask

   task automatic test_timeout();
      logic [63:0] prior;
      int s, n;
      rd_b = $urandom; rv_b = 1'b1;
      b_done_n = 0; b_rd = 0; b_wr = 0;
      start_b = 1'b1;
      step_cycles(1);
      start_b = 1'b0;
      n = 0;
      while (b_done_n == 0 && n < 100) begin step_cycles(1); n++; end
      checks++;
      if (b_done_n != 1 || b_to !== 1'b0 || b_rd != 2 || res_b !== {rd_b, rd_b}) begin
         errors++;
         $display("FAIL tmo_prerun got done=%0d to=%b reads=%0d res=%h want done=1 to=0 reads=2 res=%h",
                  b_done_n, b_to, b_rd, res_b, {rd_b, rd_b});
      end
      prior = res_b;
      rv_b = 1'b0; b_done_n = 0; b_rd = 0; b_wr = 0;
      rd_b = $urandom;
      message = {$urandom, $urandom};
      s = cyc;
      start_b = 1'b1;
      step_cycles(1);
      start_b = 1'b0;
      n = 0;
      while (b_done_n == 0 && n < 100) begin step_cycles(1); n++; end
      step_cycles(3);
      checks++;
      if (b_done_n != 1 || b_done_cyc != s + 18 + T_B + 1 || b_to !== 1'b1) begin
         errors++;
         $display("FAIL tmo_done got n=%0d cyc=%0d to=%b want n=1 cyc=%0d to=1", b_done_n, b_done_cyc, b_to, s + 18 + T_B + 1);
      end
      checks++;
      if (b_rd != 0 || b_wr != 18 || res_b !== prior) begin
         errors++;
         $display("FAIL tmo_bus got reads=%0d writes=%0d res=%h want reads=0 writes=18 res=%h", b_rd, b_wr, res_b, prior);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] m, e, md, r;
      int s, dexp;
      bit toexp;
      m = {$urandom, $urandom}; e = {$urandom, $urandom};
      md = {$urandom, $urandom}; r = {$urandom, $urandom};
      resp_delay = 10; resp_res = {$urandom, $urandom};
      clear_obs();
      start_op_a(m, e, md, r, s);
      step_cycles(9);
      checks++;
      if (we_a !== 1'b1 || addr_a !== 8'h10 || wd_a !== md[31:0]) begin
         errors++;
         $display("FAIL rst_step9 got we=%b addr=%h dat=%h want we=1 addr=10 dat=%h", we_a, addr_a, wd_a, md[31:0]);
      end
      nreset = 1'b0;
      #1;
      checks++;
      if ({we_a, re_a, addr_a, wd_a, busy_a, done_a, to_a, res_a} !== '0) begin
         errors++;
         $display("FAIL rst_async got outputs %h want 0", {we_a, re_a, addr_a, wd_a, busy_a, done_a, to_a, res_a});
      end
      step_cycles(2);
      nreset = 1'b1;
      step_cycles(1);
      checks++;
      if (done_q.size() != 0) begin
         errors++;
         $display("FAIL rst_nodone got %0d done pulses want 0", done_q.size());
      end
      clear_obs();
      m = {$urandom, $urandom}; e = {$urandom, $urandom};
      md = {$urandom, $urandom}; r = {$urandom, $urandom};
      resp_delay = 5;
      start_op_a(m, e, md, r, s);
      wait_done_a(200);
      step_cycles(3);
      build_model(m, e, md, r, s, 5, T_A, dexp, toexp);
      checks++;
      if (obs_q.size() != exp_q.size() || done_q.size() != 1 || done_q[0] != dexp || res_a !== resp_res) begin
         errors++;
         $display("FAIL rst_rerun got xfers=%0d done=%0d res=%h want xfers=%0d done=1 res=%h",
                  obs_q.size(), done_q.size(), res_a, exp_q.size(), resp_res);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rst_xfer%0d got cyc=%0d addr=%h dat=%h want cyc=%0d addr=%h dat=%h", i,
                     obs_q[i].cyc, obs_q[i].addr, obs_q[i].dat, exp_q[i].cyc, exp_q[i].addr, exp_q[i].dat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] m, e, md, r;
      int s, k, dexp;
      bit toexp;
      clear_obs();
      for (int it = 0; it < 5; it++) begin
         m = {$urandom, $urandom}; e = {$urandom, $urandom};
         md = {$urandom, $urandom}; r = {$urandom, $urandom};
         resp_res = {$urandom, $urandom};
         resp_stale = ($urandom_range(0, 3) == 0);
         resp_delay = $urandom_range(1, 40);
         k = resp_stale ? 0 : resp_delay;
         start_op_a(m, e, md, r, s);
         wait_done_a(200);
         build_model(m, e, md, r, s, k, T_A, dexp, toexp);
         checks++;
         if (done_q.size() != 1 || done_q[0] != dexp || to_seen_q[0] !== 1'b0 || res_a !== resp_res) begin
            errors++;
            $display("FAIL b2b%0d_done got n=%0d cyc=%0d res=%h want n=1 cyc=%0d res=%h", it, done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, res_a, dexp, resp_res);
         end
         checks++;
         if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b%0d_count got %0d want %0d", it, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL b2b%0d_xfer%0d got cyc=%0d rd=%b addr=%h dat=%h want cyc=%0d rd=%b addr=%h dat=%h", it, i,
                        obs_q[i].cyc, obs_q[i].rd, obs_q[i].addr, obs_q[i].dat,
                        exp_q[i].cyc, exp_q[i].rd, exp_q[i].addr, exp_q[i].dat);
            end
         end
         clear_obs();
      end
      resp_stale = 1'b0;
      step_cycles(3);
      checks++;
      if (bus_err != 0) begin
         errors++;
         $display("FAIL bus_idle got %0d clash/idle-junk cycles want 0", bus_err);
      end
   endtask

   initial begin
      nreset = 1'b0; start_a = 1'b0; start_b = 1'b0; rv_b = 1'b0; rd_b = 32'h0;
      message = '0; exponent = '0; modulus = '0; residue = '0;
      resp_res = '0; resp_delay = 10; resp_stale = 1'b0;
      b_wr = 0; b_rd = 0; b_done_n = 0; b_done_cyc = 0; b_to = 1'b0;
      test_reset();
      test_basic();
      test_stale_valid();
      test_start_while_busy();
      test_timeout();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
